// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller (16 x 1-word lines).
// Optional hit/miss statistics counters are enabled with macro DCACHE_STATS_EN.
module dcache_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int unsigned LINES  = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned TAG_W  = 26;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] WDONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              lookup_hit;
    logic              fill_en;
    logic              wupd_en;
    logic              unused_addr_lsb;

    assign idx             = addr[5:2];
    assign tag             = addr[31:6];
    assign lookup_hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign mem_addr        = {addr[31:2], 2'b00};
    assign mem_wdata       = writeData;
    assign unused_addr_lsb = ^addr[1:0];

    // State and valid bits; reset abandons any outstanding backing access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    // Tag/data storage needs no reset: valid bits qualify every lookup.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_rdata;
        end else if (wupd_en) begin
            data_q[idx] <= writeData;
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        hit      = 1'b1;
        readData = '0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        fill_en  = 1'b0;
        wupd_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (memWrite) begin
                    hit     = 1'b0;
                    state_d = WRITE;
                end else if (memRead) begin
                    if (lookup_hit) begin
                        readData = data_q[idx];
                    end else begin
                        hit     = 1'b0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                hit     = 1'b0;
                mem_req = 1'b1;
                if (mem_ready) begin
                    fill_en      = 1'b1;
                    valid_d[idx] = 1'b1;
                    state_d      = IDLE;
                end
            end
            WRITE: begin
                hit     = 1'b0;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    wupd_en = lookup_hit;
                    state_d = WDONE;
                end
            end
            WDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic        prev_fetch_q;
    logic [15:0] hit_cnt_q, miss_cnt_q;
    logic        cnt_hit_c, cnt_miss_c;

    // The first hit after a refill is the miss completing, not a new hit.
    assign cnt_hit_c  = (state_q == IDLE) && memRead && !memWrite && lookup_hit && !prev_fetch_q;
    assign cnt_miss_c = (state_q == IDLE) && (state_d == FETCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_fetch_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            prev_fetch_q <= (state_q == FETCH);
            if (cnt_hit_c && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'(1);
            end
            if (cnt_miss_c && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'(1);
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: random loads/stores against a backing-memory image and residency model.
module tb_dcache_ctrl;

    logic        clk;
    logic        rst_n;
    logic        memRead;
    logic        memWrite;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        hit;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    dcache_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .addr      (addr),
        .writeData (writeData),
        .readData  (readData),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    typedef struct {
        bit          is_write;
        logic [31:0] rdata;
        int          stalls;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_img [logic [29:0]];
    bit          m_valid [16];
    logic [29:0] m_line  [16];

    int          vectors     = 0;
    int          miscompares = 0;
    int          exp_hits    = 0;
    int          exp_miss    = 0;
    int          stall_cnt   = 0;
    int          rcnt        = 0;
    bit          done        = 0;
    bit          mon_en      = 0;
    bit          resp_en     = 1;
    int          cur_lat     = 1;
    bit          cur_is_write = 0;
    logic [31:0] cur_addr    = '0;
    logic [31:0] cur_wdata   = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Backing memory contents: written words, else a fixed address hash.
    function automatic logic [31:0] mem_val(input logic [29:0] wa);
        if (mem_img.exists(wa)) return mem_img[wa];
        return (32'(wa) * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Monitor: completes a transaction on the first hit=1 of an active request.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst_n) begin
            if (memRead || memWrite) begin
                if (!hit) begin
                    stall_cnt++;
                end else if (!done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                        check("mem_req_at_done", 32'(mem_req), 32'd0);
                        if (!e.is_write) check("readData", readData, e.rdata);
                    end
                    done = 1;
                    stall_cnt = 0;
                end
            end else begin
                check("idle_hit", 32'(hit), 32'd1);
                check("idle_readData", readData, 32'd0);
                check("idle_mem_req", 32'(mem_req), 32'd0);
                check("idle_mem_we", 32'(mem_we), 32'd0);
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
        end
    end

    // Backing memory responder: pulses mem_ready on the cur_lat-th request cycle.
    always @(negedge clk) begin
        if (resp_en) begin
            mem_ready = 1'b0;
            if (!rst_n) begin
                rcnt = 0;
            end else if (mem_req) begin
                rcnt++;
                if (rcnt == 1) begin
                    check("mem_we", 32'(mem_we), 32'(cur_is_write));
                    check("mem_addr", mem_addr, {cur_addr[31:2], 2'b00});
                    if (cur_is_write) check("mem_wdata", mem_wdata, cur_wdata);
                end
                if (rcnt >= cur_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_we ? $urandom : mem_val(mem_addr[31:2]);
                    rcnt = 0;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                             input logic [31:0] wd, input int lat);
        exp_t        e;
        logic [29:0] wa;
        int          idx;
        bit          h;
        wa  = a[31:2];
        idx = int'(wa[3:0]);
        cur_lat = lat; cur_is_write = wr; cur_addr = a; cur_wdata = wd;
        if (wr) begin
            mem_img[wa] = wd;
            e.is_write = 1; e.rdata = '0; e.stalls = 1 + lat;
        end else begin
            h = m_valid[idx] && (m_line[idx] == wa);
            e.is_write = 0; e.rdata = mem_val(wa); e.stalls = h ? 0 : 1 + lat;
            if (h) begin
                exp_hits = sat16(exp_hits + 1);
            end else begin
                exp_miss = sat16(exp_miss + 1);
                m_valid[idx] = 1; m_line[idx] = wa;
            end
        end
        exp_q.push_back(e);
        done = 0;
        addr = a; writeData = wd; memWrite = wr; memRead = rd;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
        end
        if (!done) begin
            check("access_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
        memRead = 0; memWrite = 0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        exp_hits = 0; exp_miss = 0;
        exp_q.delete();
    endtask

    task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
        check({tag, "_hit_count"}, 32'(hit_count), 32'(exp_hits));
        check({tag, "_miss_count"}, 32'(miss_count), 32'(exp_miss));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        rst_n = 0; memRead = 0; memWrite = 0; addr = '0; writeData = '0;
        mem_rdata = '0; mem_ready = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("reset_hit", 32'(hit), 32'd1);
        check("reset_readData", readData, 32'd0);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check_stats("reset");
        mon_en = 1;
        @(posedge clk); #1;

        // Directed: cold miss, repeat hit, conflict eviction, store, store+load priority.
        mem_img[30'h10] = 32'hDEADBEEF;
        do_access(0, 1, 32'h40, '0, 3);
        do_access(0, 1, 32'h40, '0, 3);
        do_access(0, 1, 32'h440, '0, 2);
        do_access(0, 1, 32'h40, '0, 1);
        do_access(1, 0, 32'h40, 32'h12345678, 2);
        do_access(0, 1, 32'h43, '0, 1);
        do_access(1, 1, 32'h80, 32'hCAFEF00D, 1);
        do_access(0, 1, 32'h40, '0, 1);
        do_access(0, 1, 32'h80, '0, 4);
        check_stats("directed");

        for (int n = 0; n < 400; n++) begin
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
              | 32'($urandom_range(0, 3));
            k = $urandom_range(0, 9);
            if (k < 6)      do_access(0, 1, a, '0, $urandom_range(1, 4));
            else if (k < 9) do_access(1, 0, a, $urandom, $urandom_range(1, 4));
            else            do_access(1, 1, a, $urandom, $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        check_stats("random");

        // Reset in the middle of a refill, then a late mem_ready pulse.
        resp_en = 0;
        mem_ready = 0;
        addr = 32'h1000; memRead = 1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        mon_en = 0;
        rst_n = 0; memRead = 0;
        @(posedge clk); #1;
        rst_n = 1; mem_ready = 1; mem_rdata = 32'h0BAD0BAD;
        clear_model();
        @(negedge clk);
        check("post_reset_hit", 32'(hit), 32'd1);
        check("post_reset_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        mem_ready = 0;
        @(negedge clk);
        check("late_ready_mem_req", 32'(mem_req), 32'd0);
        check_stats("post_reset");
        resp_en = 1;
        mon_en = 1;
        @(posedge clk); #1;
        do_access(0, 1, 32'h1000, '0, 2);
        do_access(0, 1, 32'h40, '0, 1);
        do_access(0, 1, 32'h40, '0, 1);

`ifdef DCACHE_STATS_EN
        // Hold a resident read long enough to saturate the hit counter.
        mon_en = 0;
        addr = 32'h40; memRead = 1;
        repeat (65540) @(posedge clk);
        #1 memRead = 0;
        exp_hits = sat16(exp_hits + 65540);
        @(negedge clk);
        check_stats("saturate");
        mon_en = 1;
        @(posedge clk); #1;
`endif
        check_stats("final");
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have the ports below, listed as name, direction, width, meaning.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 memRead, memWrite  in  1 each  MEM-stage access request from EX/MEM register outputs.
REQ-005 addr  in  32  byte address (EX/MEM AluResOut); word index addr[5:2], tag addr[31:6], addr[1:0] ignored.
REQ-006 writeData  in  32  store data (EX/MEM writeDataOut).
REQ-007 readData  out  32  load data to MEM/WB.
REQ-008 hit  out  1  pipeline advance enable; drives the hit input of the pipeline registers; 0 = stall.
REQ-009 mem_req, mem_we  out  1 each  backing-memory request and write strobe.
REQ-010 mem_addr  out  32  word-aligned backing address {addr[31:2],2'b00}.
REQ-011 mem_wdata  out  32  backing write data (= writeData).
REQ-012 mem_rdata  in  32  backing read data, valid when mem_ready=1.
REQ-013 mem_ready  in  1  backing-memory completion, one-cycle pulse.

Function
REQ-014 The cache SHALL be direct-mapped: 16 lines, one 32-bit word each, with a valid bit and a 26-bit tag; write-through, no write-allocate.
REQ-015 FSM states SHALL be IDLE, FETCH, WRITE, WDONE.
REQ-016 IDLE, no access: hit=1, readData=0, mem_req=0.
REQ-017 IDLE, memRead, valid and tag match: hit=1 and readData=line data, combinationally in the same cycle; zero-cycle stall.
REQ-018 IDLE, memRead miss: hit=0; next edge -> FETCH.
REQ-019 FETCH: mem_req=1, mem_we=0, hit=0; on the edge with mem_ready=1, write line data=mem_rdata, set the tag, set valid=1, -> IDLE; the following IDLE cycle hits per REQ-017.
REQ-020 IDLE, memWrite (priority over memRead when both are 1): hit=0; next edge -> WRITE.
REQ-021 WRITE: mem_req=1, mem_we=1, hit=0; on the edge with mem_ready=1, update the line word to writeData if valid and tag match (valid/tag unchanged on mismatch), -> WDONE.
REQ-022 WDONE: hit=1, mem_req=0, memWrite ignored for one cycle, then -> IDLE unconditionally; each store starts exactly one write.
REQ-023 mem_ready SHALL be ignored in IDLE and WDONE.
REQ-024 mem_addr and mem_wdata SHALL track addr and writeData combinationally; requesters hold them stable while hit=0.

Reset
REQ-025 When rst_n=0 at a rising edge: state=IDLE and all valid bits=0; tag/data contents are don't-care.
REQ-026 Reset during FETCH or WRITE SHALL abandon the access; mem_req=0 from the cycle after the reset edge, and a late mem_ready SHALL be ignored.
REQ-027 After reset the outputs SHALL be hit=1, readData=0, mem_req=0, mem_we=0.

Configuration
REQ-028 With macro DCACHE_STATS_EN defined, the block SHALL add outputs hit_count[15:0] and miss_count[15:0], both reset to 0 and saturating at 16'hFFFF.
REQ-029 hit_count SHALL increment on each IDLE read hit whose previous state was not FETCH; miss_count SHALL increment on each IDLE->FETCH transition.
REQ-030 Without DCACHE_STATS_EN, the ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-031 Reset, then memRead addr=0x40 with memory returning 0xDEADBEEF after 3 cycles -> hit=0 for 4 cycles, then hit=1 and readData=0xDEADBEEF.
REQ-032 Repeat read of 0x40 -> hit=1 the same cycle, no mem_req.
REQ-033 Read 0x440 (same index, different tag) -> miss and refill; a later read of 0x40 misses again.
REQ-034 memWrite 0x40 with data 0x12345678, mem_ready after 2 cycles -> mem_we=1 and mem_addr=0x40, one WDONE cycle with hit=1, then read 0x40 hits with 0x12345678; with memRead=memWrite=1, only the write is performed.
REQ-035 Assert rst_n=0 mid-FETCH, then pulse mem_ready -> no line valid, hit=1; with DCACHE_STATS_EN, counters=0 and saturation is checked at 0xFFFF.
